siganal_next: RTL and testbench

// - Registered immediate extender in the MIPS datapath, between instruction decode and ALU-B mux / branch adder.
// - Widens a SIGN_EXTEND_LEN-bit immediate to WORD_LEN bits.
// - Supports four modes: sign extend (I-type arith/ld/st), zero extend (logical imm), LUI upper placement,
//   and branch offset (sign extend then << 2).
// - One-cycle latency with valid tag; one clock; synchronous active-low reset.

---
 rtl/siganal_next_pkg.sv | 11 +
 rtl/siganal_next_core.sv | 20 ++
 rtl/siganal_next.sv | 33 +++
 tb/tb_siganal_next.sv | 90 +++++++++
 4 files changed

// File: rtl/siganal_next_pkg.sv
// siganal_next_pkg: shared widths and extension-mode encodings for the immediate extender
package siganal_next_pkg;
  localparam int SIGN_EXTEND_LEN = 16;
  localparam int WORD_LEN = 32;
  typedef enum logic [1:0] {
    EXT_SIGN = 2'b00,
    EXT_ZERO = 2'b01,
    EXT_LUI = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;
endpackage

// File: rtl/siganal_next_core.sv
// sign_extend_core: combinational sign/zero/lui/branch widening of an immediate
module sign_extend_core
  import siganal_next_pkg::*;
#(
  parameter int SIGN_EXTEND_LEN = siganal_next_pkg::SIGN_EXTEND_LEN,
  parameter int WORD_LEN = siganal_next_pkg::WORD_LEN
) (
  input logic [SIGN_EXTEND_LEN-1:0] in,
  input ext_mode_t mode,
  output logic [WORD_LEN-1:0] out
);
  localparam int E = WORD_LEN - SIGN_EXTEND_LEN;
  logic [WORD_LEN-1:0] sext;
  assign sext = {{E{in[SIGN_EXTEND_LEN-1]}}, in};
  always_comb
    out = mode == EXT_SIGN ? sext :
          mode == EXT_ZERO ? {{E{1'b0}}, in} :
          mode == EXT_LUI ? {in, {E{1'b0}}} :
          sext << 2;
endmodule

// File: rtl/siganal_next.sv
// siganal_next: registered immediate extender with one-cycle latency and valid tag
module siganal_next
  import siganal_next_pkg::*;
#(
  parameter int SIGN_EXTEND_LEN = siganal_next_pkg::SIGN_EXTEND_LEN,
  parameter int WORD_LEN = siganal_next_pkg::WORD_LEN
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input logic [1:0] ext_mode,
  input logic [SIGN_EXTEND_LEN-1:0] inputSignalBeforeExtension,
  output logic [WORD_LEN-1:0] outputSignalAfterExtension,
  output logic out_valid
);
  logic [WORD_LEN-1:0] ext_word;
  sign_extend_core #(
    .SIGN_EXTEND_LEN(SIGN_EXTEND_LEN),
    .WORD_LEN(WORD_LEN)
  ) u_core (
    .in(inputSignalBeforeExtension),
    .mode(ext_mode_t'(ext_mode)),
    .out(ext_word)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      outputSignalAfterExtension <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) outputSignalAfterExtension <= ext_word;
    end
endmodule

// File: tb/tb_siganal_next.sv
// tb_siganal_next: randomized and directed check of siganal_next against an arithmetic model
module tb_siganal_next;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] ext_mode = 2'b00;
  logic [15:0] imm = '0;
  logic [31:0] out;
  logic out_valid;
  logic [31:0] exp_out = '0;
  logic exp_v = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  siganal_next dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .ext_mode(ext_mode),
    .inputSignalBeforeExtension(imm),
    .outputSignalAfterExtension(out),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] i);
    longint sv;
    sv = i[15] ? longint'(i) - 65536 : longint'(i);
    case (m)
      2'd0: return 32'(sv);
      2'd1: return 32'(longint'(i));
      2'd2: return 32'(longint'(i) * 65536);
      default: return 32'(sv * 4);
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [15:0] i);
    rst_n = r;
    in_valid = v;
    ext_mode = m;
    imm = i;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_out = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_out = model(m, i);
    end
    check("out", out, exp_out);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
  endtask
  task automatic directed(input string tag, input logic [1:0] m, input logic [15:0] i, input logic [31:0] want);
    step(1'b1, 1'b1, m, i);
    check(tag, out, want);
  endtask
  initial begin
    step(1'b0, 1'b1, 2'd0, 16'h8000);
    step(1'b0, 1'b1, 2'd0, 16'h8000);
    check("reset_out", out, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    directed("sign_8000", 2'd0, 16'h8000, 32'hFFFF8000);
    directed("sign_7fff", 2'd0, 16'h7FFF, 32'h00007FFF);
    directed("sign_ffff", 2'd0, 16'hFFFF, 32'hFFFFFFFF);
    directed("sign_0000", 2'd0, 16'h0000, 32'h00000000);
    directed("zero_8000", 2'd1, 16'h8000, 32'h00008000);
    directed("lui_8000", 2'd2, 16'h8000, 32'h80000000);
    directed("lui_1234", 2'd2, 16'h1234, 32'h12340000);
    directed("br_ffff", 2'd3, 16'hFFFF, 32'hFFFFFFFC);
    directed("br_7fff", 2'd3, 16'h7FFF, 32'h0001FFFC);
    directed("br_8000", 2'd3, 16'h8000, 32'hFFFE0000);
    step(1'b1, 1'b0, 2'd1, 16'h1111);
    step(1'b1, 1'b0, 2'd2, 16'h2222);
    check("hold_out", out, 32'hFFFE0000);
    check("hold_valid", {31'b0, out_valid}, 32'h0);
    directed("sign_mid", 2'd0, 16'h8000, 32'hFFFF8000);
    step(1'b0, 1'b1, 2'd1, 16'h4321);
    check("midrst_out", out, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 2'($urandom), 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
